// File: rtl/decoder_pkg.sv
// Shared constants and types for the RV32I OP/OP-IMM decoder and the ALU behind it.
package decoder_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    // Selects how imm_gen forms the second operand.
    typedef enum logic [1:0] {
        FmtR     = 2'd0,
        FmtI     = 2'd1,
        FmtShamt = 2'd2
    } fmt_e;

endpackage

// File: rtl/decoder_imm_gen.sv
// Combinational immediate generator: sign-extended I-immediate or zero-extended shamt.
module decoder_imm_gen
    import decoder_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] instr,
    input  fmt_e            fmt,
    output logic [XLEN-1:0] imm
);

    logic unused_bits;
    assign unused_bits = ^instr[19:0];

    always_comb begin
        imm = '0;
        case (fmt)
            FmtI:     imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            FmtShamt: imm = {{(XLEN-5){1'b0}}, instr[24:20]};
            default:  imm = '0;
        endcase
    end

endmodule

// File: rtl/decoder.sv
// RV32I OP/OP-IMM field decoder with a single registered output stage.
module decoder
    import decoder_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] res,
    output logic [3:0]      alu_op,
    output logic            is_imm,
    output logic            valid
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    fmt_e            fmt;
    alu_op_e         alu_d;
    logic            valid_d;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] op2_d;
    logic [XLEN-1:0] res_d;

    decoder_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (instruction),
        .fmt   (fmt),
        .imm   (imm)
    );

    // X/Z fields fall to the default arms, so unknown encodings decode as unsupported.
    always_comb begin
        fmt     = FmtR;
        alu_d   = AluAdd;
        valid_d = 1'b0;
        case (opcode)
            OPC_OP: begin
                valid_d = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'd0}: alu_d = AluAdd;
                    {F7_BASE, 3'd1}: alu_d = AluSll;
                    {F7_BASE, 3'd2}: alu_d = AluSlt;
                    {F7_BASE, 3'd3}: alu_d = AluSltu;
                    {F7_BASE, 3'd4}: alu_d = AluXor;
                    {F7_BASE, 3'd5}: alu_d = AluSrl;
                    {F7_BASE, 3'd6}: alu_d = AluOr;
                    {F7_BASE, 3'd7}: alu_d = AluAnd;
                    {F7_ALT,  3'd0}: alu_d = AluSub;
                    {F7_ALT,  3'd5}: alu_d = AluSra;
                    default:         valid_d = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                valid_d = 1'b1;
                fmt     = FmtI;
                case ({funct7, funct3})
                    {F7_BASE, 3'd1}: begin alu_d = AluSll; fmt = FmtShamt; end
                    {F7_BASE, 3'd5}: begin alu_d = AluSrl; fmt = FmtShamt; end
                    {F7_ALT,  3'd5}: begin alu_d = AluSra; fmt = FmtShamt; end
                    default: begin
                        case (funct3)
                            3'd0:    alu_d = AluAdd;
                            3'd2:    alu_d = AluSlt;
                            3'd3:    alu_d = AluSltu;
                            3'd4:    alu_d = AluXor;
                            3'd6:    alu_d = AluOr;
                            3'd7:    alu_d = AluAnd;
                            default: valid_d = 1'b0;
                        endcase
                    end
                endcase
            end
            default: valid_d = 1'b0;
        endcase
    end

    always_comb begin
        op1_d = '0;
        op2_d = '0;
        res_d = '0;
        if (valid_d) begin
            op1_d = {{(XLEN-5){1'b0}}, instruction[19:15]};
            res_d = {{(XLEN-5){1'b0}}, instruction[11:7]};
            op2_d = (fmt == FmtR) ? {{(XLEN-5){1'b0}}, instruction[24:20]} : imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1    <= '0;
            op2    <= '0;
            res    <= '0;
            alu_op <= '0;
            is_imm <= 1'b0;
            valid  <= 1'b0;
        end else begin
            op1    <= op1_d;
            op2    <= op2_d;
            res    <= res_d;
            alu_op <= valid_d ? alu_d : AluAdd;
            is_imm <= valid_d && (fmt != FmtR);
            valid  <= valid_d;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: driver queues hand-computed decodes, monitor checks each edge.
module tb_decoder;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] res;
    logic [3:0]      alu_op;
    logic            is_imm;
    logic            valid;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] res;
        logic [3:0]  alu;
        logic        imm;
        logic        valid;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    decoder #(
        .XLEN (XLEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .op1         (op1),
        .op2         (op2),
        .res         (res),
        .alu_op      (alu_op),
        .is_imm      (is_imm),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send(input logic [31:0] ins, input logic [31:0] e_op1, input logic [31:0] e_op2,
                        input logic [31:0] e_res, input logic [3:0] e_alu, input logic e_imm,
                        input logic e_valid);
        exp_t e;
        @(negedge clk);
        instruction = ins;
        e = '{instr: ins, op1: e_op1, op2: e_op2, res: e_res, alu: e_alu, imm: e_imm,
              valid: e_valid};
        exp_q.push_back(e);
    endtask

    task automatic send_bad(input logic [31:0] ins);
        send(ins, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if ({op1, op2, res, alu_op, is_imm, valid} !== '0) begin
            n_fail++;
            $display("FAIL %s: got op1=%h op2=%h res=%h alu=%0d imm=%b valid=%b, want all 0",
                     name, op1, op2, res, alu_op, is_imm, valid);
        end
    endtask

    // Monitor: one queued decode is due after every edge taken out of reset.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_tests++;
                if (op1 !== e.op1 || op2 !== e.op2 || res !== e.res || alu_op !== e.alu ||
                    is_imm !== e.imm || valid !== e.valid) begin
                    n_fail++;
                    $display({"FAIL decode %h: got op1=%h op2=%h res=%h alu=%0d imm=%b valid=%b,",
                              " want op1=%h op2=%h res=%h alu=%0d imm=%b valid=%b"},
                             e.instr, op1, op2, res, alu_op, is_imm, valid,
                             e.op1, e.op2, e.res, e.alu, e.imm, e.valid);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        rst_n       = 1'b0;
        instruction = 32'h002081B3;
        #1;
        check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");

        // First edge after release decodes the instruction already present.
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back('{instr: 32'h002081B3, op1: 32'd1, op2: 32'd2, res: 32'd3, alu: 4'd0,
                          imm: 1'b0, valid: 1'b1});

        send(32'h407302B3, 32'd6, 32'd7, 32'd5, 4'd1, 1'b0, 1'b1);
        send(32'h4020D1B3, 32'd1, 32'd2, 32'd3, 4'd7, 1'b0, 1'b1);
        send(32'h0020F1B3, 32'd1, 32'd2, 32'd3, 4'd9, 1'b0, 1'b1);
        send(32'hFFF00093, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd0, 1'b1, 1'b1);
        send(32'h7FF00093, 32'd0, 32'h000007FF, 32'd1, 4'd0, 1'b1, 1'b1);
        send(32'h80006093, 32'd0, 32'hFFFFF800, 32'd1, 4'd8, 1'b1, 1'b1);
        send(32'h0050B113, 32'd1, 32'd5, 32'd2, 4'd4, 1'b1, 1'b1);
        send(32'h40325213, 32'd4, 32'd3, 32'd4, 4'd7, 1'b1, 1'b1);
        send(32'h01F09093, 32'd1, 32'd31, 32'd1, 4'd2, 1'b1, 1'b1);
        send_bad(32'h40321213);
        send_bad(32'h00000073);
        send_bad(32'h022081B3);
        // Held instruction must give identical outputs every cycle.
        repeat (3) send(32'h407302B3, 32'd6, 32'd7, 32'd5, 4'd1, 1'b0, 1'b1);

        // Reset pulse between edges: clears at once, next edge decodes current input.
        send(32'h4020D1B3, 32'd1, 32'd2, 32'd3, 4'd7, 1'b0, 1'b1);
        send(32'hFFF00093, 32'd0, 32'hFFFFFFFF, 32'd1, 4'd0, 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_zero("reset_midstream");
        #1 rst_n = 1'b1;
        send(32'h002081B3, 32'd1, 32'd2, 32'd3, 4'd0, 1'b0, 1'b1);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d decodes still pending, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder.md
# decoder

Instruction-field decoder for the RV32I integer register-register (OP) and register-immediate (OP-IMM) formats. It sits between the instruction memory/fetch stage and the register file/ALU. Each cycle it registers one 32-bit instruction word and produces:
- the source operand specifiers,
- the second operand (register index or sign-extended immediate),
- the destination register index,
- an ALU operation code and a validity flag.

## Interface
Parameters:
- XLEN, 32, datapath width of op1/op2/res and of the instruction word.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- instruction  input  XLEN  raw instruction word, sampled every rising edge.
- op1  output  XLEN  rs1 index (instr[19:15]), zero-extended.
- op2  output  XLEN  R-type: rs2 index zero-extended. I-type: immediate (see Operation).
- res  output  XLEN  rd index (instr[11:7]), zero-extended.
- alu_op  output  4  operation code (encoding below).
- is_imm  output  1  1 = op2 is an immediate, 0 = op2 is a register index.
- valid  output  1  1 = registered instruction is a supported OP/OP-IMM encoding.

## Operation
- Opcode instr[6:0]:
  - 0110011 → R-type.
  - 0010011 → I-type.
  - Anything else, including X/Z → unsupported.
- alu_op encoding:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4
  - XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - 10–15 unused.
- R-type, selected by funct3 = instr[14:12] and funct7 = instr[31:25]:
  - funct7 = 0000000: f3 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND.
  - funct7 = 0100000: f3 0 SUB, f3 5 SRA.
  - Any other funct7/funct3 combination is unsupported.
- I-type:
  - f3 0 ADDI, 2 SLTI, 3 SLTIU, 4 XORI, 6 ORI, 7 ANDI.
  - For these, op2 = sign-extension of instr[31:20] to XLEN.
- I-type shifts:
  - f3 1 with instr[31:25] = 0000000 → SLL.
  - f3 5 with instr[31:25] = 0000000 → SRL.
  - f3 5 with instr[31:25] = 0100000 → SRA.
  - For shifts, op2 = shamt instr[24:20] zero-extended.
  - Other upper bits are unsupported.
- Supported encoding: valid=1; is_imm=1 for I-type, 0 for R-type.
- Unsupported encoding: valid=0, and op1, op2, res, alu_op, is_imm are all 0.
- rd = x0 and rs = x0 are decoded normally; the decoder does not suppress them.

## Timing
- All outputs are registered with 1-cycle latency: the instruction sampled at edge N appears after edge N.
- A new instruction is accepted every cycle. There is no handshake, and outputs track the input continuously.
- An instruction held constant for several cycles gives stable, identical outputs.
- Reset (rst_n low) clears every output to 0 immediately, asynchronously, including valid=0.
- Outputs stay 0 while rst_n is low.
- The first edge after rst_n rises decodes the current instruction normally.
- Reset asserted mid-stream discards the pending decode. No state survives reset.

## Structure
- Shared package holds:
  - opcode constants OPC_OP, OPC_OP_IMM;
  - funct7 constants F7_BASE, F7_ALT;
  - the alu_op enum/localparams, which the ALU also consumes.
- Implementation is a single module: a combinational decode block followed by an output register stage.
- One sub-module is natural: imm_gen. It is purely combinational, takes instr and format, and returns the XLEN immediate.

## Test plan
- Reset: drive rst_n=0 with instruction 0x002081B3 → all outputs 0. Release reset; one edge later op1=1, op2=2, res=3, alu_op=ADD, is_imm=0, valid=1.
- SUB/SRA R-type: 0x407302B3 → op1=6, op2=7, res=5, alu_op=SUB. 0x4020D1B3 → op1=1, op2=2, res=3, alu_op=SRA.
- Immediate sign-extension: 0xFFF00093 (addi x1,x0,-1) → op1=0, op2=0xFFFFFFFF, res=1, alu_op=ADD, is_imm=1. 0x7FF00093 → op2=0x000007FF.
- Immediate shift: 0x40325213 (srai x4,x4,3) → op1=4, op2=3, res=4, alu_op=SRA, is_imm=1. 0x40321213 (bad slli upper bits) → valid=0, all outputs 0.
- Unsupported opcode and funct7: 0x00000073 → valid=0, outputs 0. 0x022081B3 (MUL encoding) → valid=0.
- Back-to-back and mid-stream reset:
  - Change instruction every cycle → each decode appears exactly one edge later.
  - Pulse rst_n low between edges → outputs clear asynchronously; the next post-release edge decodes the current input.
